axi_lite_irq_timer: RTL and testbench
=====================================

Name: axi_lite_irq_timer

Overview:
- AXI4-Lite slave countdown timer. It attaches to the PS GP master as a second slave port (alongside the existing AXI-Lite register slave) and runs on the 100 MHz FCLK_CLK0.
- Drives a level interrupt line into the PS interrupt input for periodic or one-shot software events.
- Register map, word-aligned, decoded on ARADDR/AWADDR[3:2]; higher address bits are ignored (the map aliases):
  - 0x0 CTRL (RW): bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, others read 0.
  - 0x4 LOAD (RW).
  - 0x8 COUNT (RO).
  - 0xC STATUS: bit0 EXPIRED, sticky, write-1-to-clear.

Parameters:
- ADDR_WIDTH, 32, width of S_AXI_ARADDR/S_AXI_AWADDR.
- PRESCALE, 1, S_AXI_ACLK cycles per COUNT decrement (>=1).

Ports:
- S_AXI_ACLK  in  1  single clock for the whole block.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR  in  ADDR_WIDTH  write address.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte strobes.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP  out  2  write response, always 2'b00.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR  in  ADDR_WIDTH  read address.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response, always 2'b00.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.
- interrupt_request  out  1  level IRQ = EXPIRED & IRQ_EN, registered.

Behaviour:
- Reset (asynchronous assert on ARESETN=0, synchronous deassert expected from the PS reset block):
  - All READY/VALID outputs = 0; RDATA = 0; BRESP/RRESP = 0.
  - CTRL = 0, LOAD = 0, COUNT = 0, EXPIRED = 0, prescaler = 0, interrupt_request = 0.
- Write channel FSM, states W_IDLE -> W_RESP:
  - In W_IDLE, when AWVALID & WVALID are both high, drive AWREADY = WREADY = 1 for exactly one cycle (cycle N). A lone AWVALID or lone WVALID is not accepted.
  - The register update takes effect at the end of cycle N.
  - BVALID = 1 from N+1 until BREADY is sampled high; then return to W_IDLE.
  - No new write is accepted while BVALID is high.
- Read channel FSM, states R_IDLE -> R_DATA, independent of the write FSM:
  - In R_IDLE, when ARVALID is high, ARREADY = 1 for one cycle (N); RDATA is captured from register state at N.
  - RVALID = 1 from N+1 until RREADY; RDATA is held stable while RVALID is high.
- Byte strobes: WSTRB masks CTRL and LOAD per byte. STATUS clear applies only if WSTRB[0] is set. Writes to COUNT are ignored but still get an OKAY response.
- Writing LOAD (any strobe) also copies the resulting LOAD value into COUNT and clears the prescaler.
- Countdown:
  - While EN=1 and COUNT!=0, the prescaler counts 0..PRESCALE-1; at PRESCALE-1, COUNT decrements by 1.
  - On the 1->0 transition: EXPIRED <= 1. If AUTO_RELOAD=1, COUNT <= LOAD (a reload of 0 stops the timer). If AUTO_RELOAD=0, EN <= 0.
  - EN=1 with COUNT=0: no decrement, no expiry event.
- interrupt_request is registered: it follows EXPIRED & IRQ_EN with 1 cycle latency.
- Simultaneous events:
  - EXPIRED set and W1C in the same cycle: set wins.
  - LOAD write and decrement in the same cycle: the LOAD write wins.
  - CTRL write clearing EN and expiry in the same cycle: EXPIRED still sets; EN ends at 0.
- Counter width: 32-bit unsigned; never underflows below 0 (the 0 state is guarded).
- Reset asserted mid-transaction: all state is dropped immediately; no response is issued for the aborted transaction.

Test Plan:
- Reset, then read 0x0/0x4/0x8/0xC -> every RDATA=0, RRESP=0, RVALID one cycle after ARREADY.
- PRESCALE=1: write LOAD=5, write CTRL=0x5 -> COUNT reads 4..0 across successive cycles; EXPIRED=1 and EN=0 after 5 decrements; interrupt_request rises 1 cycle after EXPIRED.
- CTRL=0x7, LOAD=3, BREADY held low 4 cycles -> BVALID held and no second write accepted; timer period 3 decrements, EXPIRED sticky, COUNT reloads to 3.
- Write STATUS=1 in the exact cycle COUNT hits 0 -> EXPIRED remains 1; a later write of STATUS=1 clears it and interrupt_request drops 1 cycle later.
- AWVALID presented 3 cycles before WVALID; WSTRB=4'b0001 with WDATA=0xAABBCCDD to LOAD=0 -> AWREADY/WREADY co-asserted only when both valid; LOAD reads 0x000000DD.
- Deassert ARESETN while RVALID=1 and COUNT=100 -> RVALID, COUNT, CTRL and interrupt_request go to 0 asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/axi_lite_irq_timer.sv
// AXI4-Lite countdown timer with a registered level interrupt.
// Ports:
//   S_AXI_ACLK / S_AXI_ARESETN  clock, async active-low reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B*  write address, data and response channels
//   S_AXI_AR* / S_AXI_R*              read address and data channels
//   interrupt_request                 EXPIRED & IRQ_EN, one cycle latency
// Register map (addr[3:2]): 0 CTRL {IRQ_EN,AUTO_RELOAD,EN}, 1 LOAD,
// 2 COUNT (RO), 3 STATUS {EXPIRED} write-1-to-clear.
module axi_lite_irq_timer #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned PRESCALE   = 1
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [31:0]           S_AXI_WDATA,
  input  logic [3:0]            S_AXI_WSTRB,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [31:0]           S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  output logic                  interrupt_request
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_state_d;
  r_state_t r_state, r_state_d;
  logic awready_d, bvalid_d, arready_d, rvalid_d;
  logic [DATA_W-1:0] rdata_d, rd_mux;
  logic wr_fire, rd_fire;

  logic en, auto_reload, irq_en, expired;
  logic [DATA_W-1:0] load, count, load_new;
  logic [PRE_W-1:0] presc;
  logic [1:0] wr_sel;
  logic tick, expire;

  // Address bits outside [3:2] alias the map
  logic unused_addr_bits;
  assign unused_addr_bits = ^{S_AXI_AWADDR[ADDR_WIDTH-1:4], S_AXI_AWADDR[1:0],
                              S_AXI_ARADDR[ADDR_WIDTH-1:4], S_AXI_ARADDR[1:0]};

  assign S_AXI_WREADY = S_AXI_AWREADY;
  assign S_AXI_BRESP  = 2'b00;
  assign S_AXI_RRESP  = 2'b00;
  assign wr_sel       = S_AXI_AWADDR[3:2];

  // Write channel: ready pulses for one cycle once both AW and W are valid
  always_comb begin
    w_state_d = w_state;
    awready_d = 1'b0;
    bvalid_d  = S_AXI_BVALID;
    wr_fire   = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        if (S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID) begin
          wr_fire   = 1'b1;
          bvalid_d  = 1'b1;
          w_state_d = W_RESP;
        end else if (!S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID) begin
          awready_d = 1'b1;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
    endcase
  end

  // Read data source, sampled in the address handshake cycle
  always_comb begin
    rd_mux = '0;
    unique case (S_AXI_ARADDR[3:2])
      REG_CTRL:   rd_mux = {29'd0, irq_en, auto_reload, en};
      REG_LOAD:   rd_mux = load;
      REG_COUNT:  rd_mux = count;
      REG_STATUS: rd_mux = {31'd0, expired};
    endcase
  end

  // Read channel: RDATA is captured once and held while RVALID is high
  always_comb begin
    r_state_d = r_state;
    arready_d = 1'b0;
    rvalid_d  = S_AXI_RVALID;
    rdata_d   = S_AXI_RDATA;
    rd_fire   = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        if (S_AXI_ARREADY && S_AXI_ARVALID) begin
          rd_fire   = 1'b1;
          rdata_d   = rd_mux;
          rvalid_d  = 1'b1;
          r_state_d = R_DATA;
        end else if (!S_AXI_ARREADY && S_AXI_ARVALID) begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
    endcase
  end

  // Channel state and registered handshake outputs
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state       <= W_IDLE;
      r_state       <= R_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
    end else begin
      w_state       <= w_state_d;
      r_state       <= r_state_d;
      S_AXI_AWREADY <= awready_d;
      S_AXI_BVALID  <= bvalid_d;
      S_AXI_ARREADY <= arready_d;
      S_AXI_RVALID  <= rvalid_d;
      S_AXI_RDATA   <= rdata_d;
    end
  end

  // Byte-strobe merge of write data into LOAD
  always_comb begin
    load_new = load;
    for (int i = 0; i < 4; i++) begin
      if (S_AXI_WSTRB[i]) load_new[8*i +: 8] = S_AXI_WDATA[8*i +: 8];
    end
  end

  assign tick   = en && (count != '0) && (presc == PRE_LAST);
  assign expire = tick && (count == DATA_W'(1));

  // Timer registers; later assignments express priority (LOAD write over
  // decrement, expiry over W1C, expiry clearing EN after a CTRL write)
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      en                <= 1'b0;
      auto_reload       <= 1'b0;
      irq_en            <= 1'b0;
      expired           <= 1'b0;
      load              <= '0;
      count             <= '0;
      presc             <= '0;
      interrupt_request <= 1'b0;
    end else begin
      if (wr_fire && (wr_sel == REG_LOAD)) begin
        load  <= load_new;
        count <= load_new;
        presc <= '0;
      end else if (en && (count != '0)) begin
        presc <= tick ? '0 : presc + PRE_W'(1);
        if (tick) count <= (expire && auto_reload) ? load : count - DATA_W'(1);
      end

      if (wr_fire && (wr_sel == REG_CTRL) && S_AXI_WSTRB[0]) begin
        {irq_en, auto_reload, en} <= S_AXI_WDATA[2:0];
      end
      if (expire && !auto_reload) en <= 1'b0;

      if (expire) begin
        expired <= 1'b1;
      end else if (wr_fire && (wr_sel == REG_STATUS) && S_AXI_WSTRB[0] && S_AXI_WDATA[0]) begin
        expired <= 1'b0;
      end

      interrupt_request <= expired && irq_en;
    end
  end

endmodule

// File: tb/tb_axi_lite_irq_timer.sv
// Directed bench for axi_lite_irq_timer: read expectations go through a
// scoreboard queue (pushed at address acceptance, popped when RVALID shows).
module tb_axi_lite_irq_timer;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready, irq;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  axi_lite_irq_timer #(.ADDR_WIDTH(AW), .PRESCALE(1)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .interrupt_request(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic irq_hist [0:4095];
  always @(negedge clk) if (cyc < 4096) irq_hist[cyc] <= irq;

  logic [31:0] sb_q [$];
  int total = 0;
  int bad   = 0;
  int t_load = 1;
  int t_n    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected COUNT in cycle m for a timer enabled by a CTRL write in cycle t_n
  function automatic logic [31:0] model_oneshot(input int m);
    int d;
    d = m - t_n - 1;
    return (d >= t_load) ? 32'd0 : 32'(t_load - d);
  endfunction

  function automatic logic [31:0] model_reload(input int m);
    int d;
    d = m - t_n - 1;
    return 32'(t_load - (d % t_load));
  endfunction

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int lead, input int hold, output int hs);
    int n;
    awaddr = addr; awvalid = 1'b1; bready = 1'b0;
    for (int i = 0; i < lead; i++) begin
      @(negedge clk);
      chk("aw_alone_not_accepted", 32'({awready, wready}), 32'h0);
    end
    wdata = data; wstrb = strb; wvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 20);
    hs = cyc;
    chk("w_handshake", 32'({awready, wready}), 32'h3);
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk);
      chk("b_valid_no_second_accept", 32'({bvalid, awready, bresp}), 32'h8);
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    chk("b_released", 32'(bvalid), 32'h0);
    bready = 1'b0;
  endtask

  // mode 0: fixed expectation, 1: one-shot countdown, 2: auto-reload countdown
  task automatic axi_read(input logic [31:0] addr, input int mode, input logic [31:0] exp_fixed,
                          input int rhold, input string tag);
    int n, m;
    logic [31:0] exp, got;
    araddr = addr; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 20);
    chk({tag, "_arready"}, 32'(arready), 32'h1);
    m = cyc;
    case (mode)
      1:       exp = model_oneshot(m);
      2:       exp = model_reload(m);
      default: exp = exp_fixed;
    endcase
    sb_q.push_back(exp);
    got = '0;
    for (int i = 0; i <= rhold; i++) begin
      @(negedge clk);
      arvalid = 1'b0;
      chk({tag, "_rvalid"}, 32'({rvalid, arready, rresp}), 32'h8);
      if (i == 0) got = rdata;
      else chk({tag, "_rdata_stable"}, rdata, got);
    end
    chk(tag, got, sb_q.pop_front());
    rready = 1'b1;
    @(negedge clk);
    chk({tag, "_rvalid_drop"}, 32'(rvalid), 32'h0);
    rready = 1'b0;
  endtask

  initial begin
    int hs, n, c;
    logic [31:0] frozen;
    rst_n = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({awready, wready, bvalid, arready, rvalid, irq, bresp, rresp}), 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset values of every register
    axi_read(32'h0, 0, 32'h0, 0, "rst_ctrl");
    axi_read(32'h4, 0, 32'h0, 0, "rst_load");
    axi_read(32'h8, 0, 32'h0, 1, "rst_count");
    axi_read(32'hC, 0, 32'h0, 0, "rst_status");

    // One-shot: LOAD=5, CTRL=EN|IRQ_EN
    axi_write(32'h4, 32'd5, 4'hF, 0, 0, hs);
    axi_read(32'h8, 0, 32'd5, 0, "load_copies_count");
    axi_write(32'h0, 32'h5, 4'hF, 0, 0, hs);
    wait_to(hs + 8);
    chk("irq_low_while_expiring", 32'(irq_hist[hs + 6]), 32'h0);
    chk("irq_rise_after_expired", 32'(irq_hist[hs + 7]), 32'h1);
    axi_read(32'h8, 0, 32'h0, 0, "oneshot_count_zero");
    axi_read(32'h0, 0, 32'h4, 0, "oneshot_en_cleared");
    axi_read(32'hC, 0, 32'h1, 0, "oneshot_expired");

    // W1C clears EXPIRED, interrupt drops one cycle later
    axi_write(32'hC, 32'h1, 4'h1, 0, 0, hs);
    wait_to(hs + 3);
    chk("irq_still_high_after_w1c", 32'(irq_hist[hs + 1]), 32'h1);
    chk("irq_drop_after_w1c", 32'(irq_hist[hs + 2]), 32'h0);
    axi_read(32'hC, 0, 32'h0, 0, "status_cleared");

    // Live countdown observed at several capture cycles, then stopped
    axi_write(32'h4, 32'd40, 4'hF, 0, 0, hs);
    axi_write(32'h0, 32'h1, 4'hF, 0, 0, hs);
    t_load = 40; t_n = hs;
    for (int i = 0; i < 3; i++) axi_read(32'h8, 1, 32'h0, 0, "live_count");
    axi_write(32'h0, 32'h0, 4'hF, 0, 0, c);
    frozen = model_oneshot(c + 1);
    axi_read(32'h8, 0, frozen, 0, "count_frozen_by_en0");

    // Auto-reload period 3 with write response back-pressure
    axi_write(32'h4, 32'd3, 4'hF, 0, 0, hs);
    axi_write(32'h0, 32'h7, 4'hF, 0, 4, hs);
    t_load = 3; t_n = hs;
    axi_read(32'h8, 2, 32'h0, 0, "reload_count_a");
    axi_read(32'h8, 2, 32'h0, 0, "reload_count_b");
    axi_read(32'hC, 0, 32'h1, 0, "reload_expired_sticky");
    axi_write(32'h0, 32'h4, 4'hF, 0, 0, c);
    frozen = model_reload(c + 1);
    axi_read(32'h8, 0, frozen, 0, "reload_count_frozen");
    chk("reload_irq_level", 32'(irq), 32'h1);

    // W1C landing in the same cycle as expiry: set wins
    axi_write(32'hC, 32'h1, 4'h1, 0, 0, hs);
    axi_read(32'hC, 0, 32'h0, 0, "status_cleared_again");
    axi_write(32'h4, 32'd10, 4'hF, 0, 0, hs);
    axi_write(32'h0, 32'h5, 4'hF, 0, 0, hs);
    n = hs;
    wait_to(n + 9);
    axi_write(32'hC, 32'h1, 4'hF, 0, 0, hs);
    chk("w1c_hits_expiry_cycle", 32'(hs), 32'(n + 10));
    axi_read(32'hC, 0, 32'h1, 0, "set_beats_w1c");
    axi_read(32'h0, 0, 32'h4, 0, "race_en_cleared");
    axi_read(32'h8, 0, 32'h0, 0, "race_count_zero");

    // Strobes, late WVALID, aliasing, ignored COUNT write
    axi_write(32'h4, 32'h0, 4'hF, 0, 0, hs);
    axi_write(32'h4, 32'hAABBCCDD, 4'b0001, 3, 0, hs);
    axi_read(32'h4, 0, 32'h000000DD, 0, "strobe_load_byte0");
    axi_read(32'h14, 0, 32'h000000DD, 0, "alias_load");
    axi_read(32'h8, 0, 32'h000000DD, 0, "strobe_count_copy");
    axi_write(32'h4, 32'h00110000, 4'b0100, 0, 0, hs);
    axi_read(32'h4, 0, 32'h001100DD, 0, "strobe_load_byte2");
    axi_write(32'h0, 32'h7, 4'b1110, 0, 0, hs);
    axi_read(32'h0, 0, 32'h4, 0, "ctrl_strobe_masked");
    axi_write(32'h8, 32'h1234, 4'hF, 0, 0, hs);
    axi_read(32'h8, 0, 32'h001100DD, 0, "count_write_ignored");

    // Reset while a read response is pending
    axi_write(32'h4, 32'd100, 4'hF, 0, 0, hs);
    chk("pre_reset_irq", 32'(irq), 32'h1);
    araddr = 32'h8; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 20);
    sb_q.push_back(32'd100);
    @(negedge clk);
    arvalid = 1'b0;
    chk("pre_reset_rvalid", 32'(rvalid), 32'h1);
    chk("pre_reset_rdata", rdata, sb_q.pop_front());
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({rvalid, irq, arready, bvalid}), 32'h0);
    chk("async_reset_rdata", rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("no_stale_response", 32'({rvalid, bvalid}), 32'h0);
    axi_read(32'h0, 0, 32'h0, 0, "post_reset_ctrl");
    axi_read(32'h8, 0, 32'h0, 0, "post_reset_count");
    axi_read(32'hC, 0, 32'h0, 0, "post_reset_status");
    chk("post_reset_sb_empty", 32'(sb_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
